ext_world_port_bridge: RTL and testbench

Bridges the processor's four 8-bit external-world ports to two valid/ready byte streams on the system side. Every value change on an `OutExtWorldN` port is turned into a tagged FIFO entry for an external consumer. Tagged bytes from an external producer are written into the registers that drive `InpExtWorldN`. The bridge sits beside `RISCprocessor` and is the other end of its external-world interface.

---
 rtl/ext_port_pkg.sv | 12 +
 rtl/ext_port_fifo.sv | 49 ++++
 rtl/ext_world_port_bridge.sv | 136 +++++++++++++
 tb/tb_ext_world_port_bridge.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ext_port_pkg.sv
// rtl/ext_port_pkg.sv - shared types and sizes for the external-world port bridge
package ext_port_pkg;

   localparam int NPORTS = 4;
   localparam int PORT_W = 2;

   typedef struct packed {
      logic [PORT_W-1:0] port;
      logic [7:0]        data;
   } port_entry_t;

endpackage

// File: rtl/ext_port_fifo.sv
// rtl/ext_port_fifo.sv - synchronous FIFO of tagged port entries
module ext_port_fifo
   import ext_port_pkg::*;
#(
   parameter int DEPTH = 8
)
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  port_entry_t              wdata,
   input  logic                     pop,
   output port_entry_t              rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   port_entry_t mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        do_push;
   logic        do_pop;

   // Extra pointer MSB distinguishes full from empty when the low bits match.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count   = wr_ptr - rd_ptr;
   assign rdata   = mem[rd_ptr[AW-1:0]];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/ext_world_port_bridge.sv
// rtl/ext_world_port_bridge.sv - processor external-world ports to tagged byte streams
module ext_world_port_bridge
   import ext_port_pkg::*;
#(
   parameter int         DEPTH   = 8,
   parameter logic [7:0] INP_RST = 8'h00
)
(
   input  logic                     clk,
   input  logic                     Reset_n,
   input  logic [7:0]               OutExtWorld1,
   input  logic [7:0]               OutExtWorld2,
   input  logic [7:0]               OutExtWorld3,
   input  logic [7:0]               OutExtWorld4,
   output logic [7:0]               InpExtWorld1,
   output logic [7:0]               InpExtWorld2,
   output logic [7:0]               InpExtWorld3,
   output logic [7:0]               InpExtWorld4,
   output logic [7:0]               tx_data,
   output logic [1:0]               tx_port,
   output logic                     tx_valid,
   input  logic                     tx_ready,
   input  logic [7:0]               rx_data,
   input  logic [1:0]               rx_port,
   input  logic                     rx_valid,
   output logic                     rx_ready,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     overflow,
   input  logic                     ovf_clr
);

   logic [7:0]        out_val [NPORTS];
   logic [7:0]        prev    [NPORTS];
   logic [7:0]        inp     [NPORTS];
   logic [NPORTS-1:0] chg;
   logic [NPORTS-1:0] pend;
   logic [NPORTS-1:0] elig;
   logic [NPORTS-1:0] pend_next;
   logic [PORT_W-1:0] rr;
   logic [PORT_W-1:0] grant;
   logic [PORT_W-1:0] idx;
   logic              any_elig;
   logic              push;
   logic              pop;
   logic              full;
   logic              empty;
   logic              ovf_set;
   port_entry_t       wr_entry;
   port_entry_t       head;

   assign out_val[0] = OutExtWorld1;
   assign out_val[1] = OutExtWorld2;
   assign out_val[2] = OutExtWorld3;
   assign out_val[3] = OutExtWorld4;

   assign InpExtWorld1 = inp[0];
   assign InpExtWorld2 = inp[1];
   assign InpExtWorld3 = inp[2];
   assign InpExtWorld4 = inp[3];

   always_comb begin
      chg = '0;
      for (int i = 0; i < NPORTS; i++) chg[i] = (out_val[i] != prev[i]);
      elig = pend | chg;
   end

   // Scan offsets from farthest to nearest so the port closest to rr wins.
   always_comb begin
      grant    = rr;
      any_elig = 1'b0;
      idx      = rr;
      for (int k = NPORTS-1; k >= 0; k--) begin
         idx = rr + PORT_W'(k);
         if (elig[idx]) begin
            grant    = idx;
            any_elig = 1'b1;
         end
      end
   end

   assign tx_valid = !empty;
   assign pop      = tx_valid && tx_ready;
   assign push     = any_elig && (!full || pop);
   assign wr_entry = '{port: grant, data: out_val[grant]};
   assign tx_data  = head.data;
   assign tx_port  = head.port;

   // A fresh change on a port whose previous value is still unsent loses that value.
   assign ovf_set  = |(chg & pend);

   always_comb begin
      pend_next = '0;
      for (int i = 0; i < NPORTS; i++)
         pend_next[i] = elig[i] && !(push && (grant == PORT_W'(i)));
   end

   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < NPORTS; i++) prev[i] <= '0;
         pend     <= '0;
         rr       <= '0;
         overflow <= 1'b0;
      end else begin
         for (int i = 0; i < NPORTS; i++) prev[i] <= out_val[i];
         pend <= pend_next;
         if (push) rr <= grant + 1'b1;
         if (ovf_set)      overflow <= 1'b1;
         else if (ovf_clr) overflow <= 1'b0;
      end
   end

   assign rx_ready = Reset_n;

   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < NPORTS; i++) inp[i] <= INP_RST;
      end else if (rx_valid && rx_ready) begin
         inp[rx_port] <= rx_data;
      end
   end

   ext_port_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (Reset_n),
      .push  (push),
      .wdata (wr_entry),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );

endmodule

// File: tb/tb_ext_world_port_bridge.sv
// tb/tb_ext_world_port_bridge.sv - directed self-checking bench for ext_world_port_bridge
module tb_ext_world_port_bridge;

   logic       clk = 1'b0;
   logic       Reset_n;
   logic [7:0] o1, o2, o3, o4;
   logic [7:0] i1, i2, i3, i4;
   logic [7:0] tx_data;
   logic [1:0] tx_port;
   logic       tx_valid, tx_ready;
   logic [7:0] rx_data;
   logic [1:0] rx_port;
   logic       rx_valid, rx_ready;
   logic [3:0] fifo_count;
   logic       overflow, ovf_clr;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ext_world_port_bridge #(.DEPTH(8), .INP_RST(8'h5A)) dut (
      .clk(clk), .Reset_n(Reset_n),
      .OutExtWorld1(o1), .OutExtWorld2(o2), .OutExtWorld3(o3), .OutExtWorld4(o4),
      .InpExtWorld1(i1), .InpExtWorld2(i2), .InpExtWorld3(i3), .InpExtWorld4(i4),
      .tx_data(tx_data), .tx_port(tx_port), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_port(rx_port), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .fifo_count(fifo_count), .overflow(overflow), .ovf_clr(ovf_clr)
   );

   typedef struct {
      logic [7:0] o1, o2, o3, o4;
      logic       rdy, rv;
      logic [1:0] rp;
      logic [7:0] rd;
      logic       ev;
      logic [1:0] ep;
      logic [7:0] ed;
      logic [3:0] ec;
      logic [7:0] e1, e2, e3, e4;
   } vec_t;

   vec_t vecs [13];

   function automatic vec_t mk(input logic [7:0] a, b, c, d, input logic rdy, rv,
                               input logic [1:0] rp, input logic [7:0] rd,
                               input logic ev, input logic [1:0] ep, input logic [7:0] ed,
                               input logic [3:0] ec, input logic [7:0] e1, e2, e3, e4);
      vec_t v;
      v.o1 = a; v.o2 = b; v.o3 = c; v.o4 = d; v.rdy = rdy; v.rv = rv; v.rp = rp; v.rd = rd;
      v.ev = ev; v.ep = ep; v.ed = ed; v.ec = ec; v.e1 = e1; v.e2 = e2; v.e3 = e3; v.e4 = e4;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_head(input string name, input logic [1:0] p, input logic [7:0] d);
      check({name, " valid"}, 32'(tx_valid), 32'd1);
      check({name, " port"}, 32'(tx_port), 32'(p));
      check({name, " data"}, 32'(tx_data), 32'(d));
   endtask

   logic [7:0] exp_d;

   initial begin
      vecs[0]  = mk(8'h11, 8'h22, 8'h33, 8'h44, 1, 0, 0, 8'h00, 1, 0, 8'h11, 1, 8'h5A, 8'h5A, 8'h5A, 8'h5A);
      vecs[1]  = mk(8'h11, 8'h22, 8'h33, 8'h44, 1, 0, 0, 8'h00, 1, 1, 8'h22, 1, 8'h5A, 8'h5A, 8'h5A, 8'h5A);
      vecs[2]  = mk(8'h11, 8'h22, 8'h33, 8'h44, 1, 0, 0, 8'h00, 1, 2, 8'h33, 1, 8'h5A, 8'h5A, 8'h5A, 8'h5A);
      vecs[3]  = mk(8'h11, 8'h22, 8'h33, 8'h44, 1, 0, 0, 8'h00, 1, 3, 8'h44, 1, 8'h5A, 8'h5A, 8'h5A, 8'h5A);
      vecs[4]  = mk(8'h11, 8'h22, 8'h33, 8'h44, 1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h5A, 8'h5A, 8'h5A, 8'h5A);
      vecs[5]  = mk(8'h11, 8'h8B, 8'h33, 8'h44, 1, 0, 0, 8'h00, 1, 1, 8'h8B, 1, 8'h5A, 8'h5A, 8'h5A, 8'h5A);
      vecs[6]  = mk(8'h11, 8'h8B, 8'h33, 8'h44, 1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h5A, 8'h5A, 8'h5A, 8'h5A);
      vecs[7]  = mk(8'h11, 8'h8B, 8'h33, 8'h44, 1, 1, 2, 8'hC3, 0, 0, 8'h00, 0, 8'h5A, 8'h5A, 8'hC3, 8'h5A);
      vecs[8]  = mk(8'h11, 8'h8B, 8'h33, 8'h44, 1, 1, 0, 8'h01, 0, 0, 8'h00, 0, 8'h01, 8'h5A, 8'hC3, 8'h5A);
      vecs[9]  = mk(8'h11, 8'h8B, 8'h33, 8'h44, 1, 0, 3, 8'hFF, 0, 0, 8'h00, 0, 8'h01, 8'h5A, 8'hC3, 8'h5A);
      vecs[10] = mk(8'h11, 8'h8B, 8'h33, 8'h45, 0, 1, 3, 8'hFF, 1, 3, 8'h45, 1, 8'h01, 8'h5A, 8'hC3, 8'hFF);
      vecs[11] = mk(8'h11, 8'h8B, 8'h33, 8'h45, 0, 0, 3, 8'hFF, 1, 3, 8'h45, 1, 8'h01, 8'h5A, 8'hC3, 8'hFF);
      vecs[12] = mk(8'h11, 8'h8B, 8'h33, 8'h45, 1, 0, 3, 8'hFF, 0, 0, 8'h00, 0, 8'h01, 8'h5A, 8'hC3, 8'hFF);

      Reset_n = 1'b0;
      o1 = 8'h00; o2 = 8'h00; o3 = 8'h00; o4 = 8'h00;
      tx_ready = 1'b0; rx_valid = 1'b0; rx_port = 2'd0; rx_data = 8'h00; ovf_clr = 1'b0;
      #12;
      check("rst inp1", 32'(i1), 32'h5A);
      check("rst inp2", 32'(i2), 32'h5A);
      check("rst inp3", 32'(i3), 32'h5A);
      check("rst inp4", 32'(i4), 32'h5A);
      check("rst tx_valid", 32'(tx_valid), 32'd0);
      check("rst fifo_count", 32'(fifo_count), 32'd0);
      check("rst rx_ready", 32'(rx_ready), 32'd0);
      check("rst overflow", 32'(overflow), 32'd0);
      Reset_n = 1'b1;
      #1;
      check("rx_ready after release", 32'(rx_ready), 32'd1);

      for (int v = 0; v < 13; v++) begin
         o1 = vecs[v].o1; o2 = vecs[v].o2; o3 = vecs[v].o3; o4 = vecs[v].o4;
         tx_ready = vecs[v].rdy; rx_valid = vecs[v].rv; rx_port = vecs[v].rp; rx_data = vecs[v].rd;
         step();
         check($sformatf("vec%0d tx_valid", v), 32'(tx_valid), 32'(vecs[v].ev));
         check($sformatf("vec%0d fifo_count", v), 32'(fifo_count), 32'(vecs[v].ec));
         if (vecs[v].ev) begin
            check($sformatf("vec%0d tx_port", v), 32'(tx_port), 32'(vecs[v].ep));
            check($sformatf("vec%0d tx_data", v), 32'(tx_data), 32'(vecs[v].ed));
         end
         check($sformatf("vec%0d inp1", v), 32'(i1), 32'(vecs[v].e1));
         check($sformatf("vec%0d inp2", v), 32'(i2), 32'(vecs[v].e2));
         check($sformatf("vec%0d inp3", v), 32'(i3), 32'(vecs[v].e3));
         check($sformatf("vec%0d inp4", v), 32'(i4), 32'(vecs[v].e4));
         check($sformatf("vec%0d overflow", v), 32'(overflow), 32'd0);
      end
      rx_valid = 1'b0;

      // Port 2 increments every cycle into a stalled consumer.
      tx_ready = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         o2 = 8'h40 + 8'(i);
         step();
         if (i == 8) begin
            check("fill count at 8", 32'(fifo_count), 32'd8);
            check("no overflow at fill", 32'(overflow), 32'd0);
         end
      end
      check("full count", 32'(fifo_count), 32'd8);
      check("coalesce overflow", 32'(overflow), 32'd1);
      check_head("full head", 2'd1, 8'h41);

      tx_ready = 1'b1;
      step();
      check("full push+pop count", 32'(fifo_count), 32'd8);
      for (int j = 0; j < 8; j++) begin
         exp_d = (j < 7) ? 8'h42 + 8'(j) : 8'h4C;
         check_head($sformatf("drain%0d", j), 2'd1, exp_d);
         step();
      end
      check("drained valid", 32'(tx_valid), 32'd0);
      check("drained count", 32'(fifo_count), 32'd0);
      check("overflow sticky", 32'(overflow), 32'd1);

      ovf_clr = 1'b1;
      step();
      check("overflow cleared", 32'(overflow), 32'd0);
      ovf_clr = 1'b0;
      o3 = 8'h34; o4 = 8'h46;
      step();
      check_head("two-port grant", 2'd2, 8'h34);
      check("no overflow yet", 32'(overflow), 32'd0);
      o4 = 8'h47; ovf_clr = 1'b1;
      step();
      check("set beats clr", 32'(overflow), 32'd1);
      check_head("pending port", 2'd3, 8'h47);
      step();
      check("clr after set", 32'(overflow), 32'd0);
      check("empty after pair", 32'(fifo_count), 32'd0);
      ovf_clr = 1'b0;

      // Queue five entries, then reset between clock edges.
      tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         o1 = 8'h61 + 8'(i);
         step();
      end
      check("queued count", 32'(fifo_count), 32'd5);
      #2;
      Reset_n = 1'b0;
      #1;
      check("async rst tx_valid", 32'(tx_valid), 32'd0);
      check("async rst count", 32'(fifo_count), 32'd0);
      check("async rst rx_ready", 32'(rx_ready), 32'd0);
      check("async rst inp1", 32'(i1), 32'h5A);
      check("async rst inp4", 32'(i4), 32'h5A);
      step();
      #2;
      Reset_n = 1'b1;
      step();
      check_head("post-reset first", 2'd0, 8'h65);
      check("post-reset count", 32'(fifo_count), 32'd1);
      step();
      step();
      step();
      check("post-reset all ports", 32'(fifo_count), 32'd4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
